ss_peak_detect: RTL and testbench

//  Consumes the correlator output stream (push_corr/corr) downstream of the ss block.

---
 rtl/ss_pkg.sv | 28 ++
 rtl/ss_pd_fifo.sv | 55 +++++
 rtl/ss_peak_detect.sv | 123 ++++++++++++
 tb/tb_ss_peak_detect.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// Shared types and constants for the ss correlator back-end blocks.
// Holds the peak-detector decision record layout and register map.
package ss_pkg;

  typedef struct packed {
    logic        detect;
    logic        sign;
    logic [7:0]  idx;
    logic [21:0] mag;
  } ss_pd_rec_t;

  localparam logic [3:0]  SS_PD_THRESH = 4'd0;
  localparam logic [3:0]  SS_PD_WIN    = 4'd1;
  localparam logic [3:0]  SS_PD_CTRL   = 4'd2;
  localparam logic [21:0] MAG_MAX      = 22'h3FFFFF;

  // The most negative input has no positive twin, so it clamps to the largest positive value.
  function automatic logic [31:0] ss_abs(input logic [31:0] v);
    if (!v[31])               return v;
    else if (v == 32'h80000000) return 32'h7FFFFFFF;
    else                      return ~v + 32'd1;
  endfunction

  function automatic logic [21:0] ss_sat22(input logic [31:0] m);
    return (m > {10'd0, MAG_MAX}) ? MAG_MAX : m[21:0];
  endfunction

endpackage

// File: rtl/ss_pd_fifo.sv
// Small synchronous FIFO for peak-detector decision records.
// A push while full is still taken when a pop happens in the same cycle.
module ss_pd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [3:0]   count
);
  import ss_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == 4'd0);
  assign full    = (count == 4'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 4'd0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ss_peak_detect.sv
// Windowed |corr| peak detector: one decision record per window, queued for a valid/ready consumer.
// Configuration registers share the correlator's strobe/addr/din bus style.
module ss_peak_detect #(
  parameter int DEPTH   = 4,
  parameter int WIN_RST = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] din,
  input  logic [3:0]  addr,
  input  logic        strobe,
  output logic [31:0] dout,
  input  logic        sync,
  input  logic        push_corr,
  input  logic [31:0] corr,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);
  import ss_pkg::*;

  logic [31:0] thresh;
  logic [8:0]  win;
  logic        enable, ovf;
  logic [7:0]  cnt, peak_idx, last_idx;
  logic [31:0] peak_mag, mag, nxt_mag;
  logic        peak_sign, nxt_sign;
  logic [7:0]  nxt_idx;
  logic        reg_wr, win_clear, sample, last, pop, ovf_set;
  logic        fifo_full, fifo_empty;
  logic [3:0]  fifo_count;
  ss_pd_rec_t  rec;

  assign reg_wr    = strobe && (addr == SS_PD_THRESH || addr == SS_PD_WIN || addr == SS_PD_CTRL);
  assign win_clear = sync || reg_wr;
  assign sample    = push_corr && enable && !win_clear;
  // WIN of 0 and 256 share the low byte 0, so both wrap to a last index of 255.
  assign last_idx  = win[7:0] - 8'd1;
  assign last      = sample && (cnt == last_idx);
  assign pop       = out_valid && out_ready;
  assign ovf_set   = last && fifo_full && !pop;
  assign mag       = ss_abs(corr);

  always_comb begin
    nxt_mag  = peak_mag;
    nxt_sign = peak_sign;
    nxt_idx  = peak_idx;
    if (mag > peak_mag) begin
      nxt_mag  = mag;
      nxt_sign = corr[31];
      nxt_idx  = cnt;
    end
    rec.detect = (nxt_mag >= thresh);
    rec.sign   = nxt_sign;
    rec.idx    = nxt_idx;
    rec.mag    = ss_sat22(nxt_mag);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= 8'd0;
      peak_mag  <= 32'd0;
      peak_sign <= 1'b0;
      peak_idx  <= 8'd0;
    end else if (win_clear || last) begin
      cnt       <= 8'd0;
      peak_mag  <= 32'd0;
      peak_sign <= 1'b0;
      peak_idx  <= 8'd0;
    end else if (sample) begin
      cnt       <= cnt + 8'd1;
      peak_mag  <= nxt_mag;
      peak_sign <= nxt_sign;
      peak_idx  <= nxt_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thresh <= 32'd0;
      win    <= 9'(WIN_RST);
      enable <= 1'b1;
    end else if (strobe) begin
      case (addr)
        SS_PD_THRESH: thresh <= din;
        SS_PD_WIN:    win    <= din[8:0];
        SS_PD_CTRL:   enable <= din[0];
        default:      ;
      endcase
    end
  end

  // A fresh overflow outranks a clear request in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  ovf <= 1'b0;
    else if (ovf_set)                              ovf <= 1'b1;
    else if (strobe && addr == SS_PD_CTRL && din[1]) ovf <= 1'b0;
  end

  always_comb begin
    case (addr)
      SS_PD_THRESH: dout = thresh;
      SS_PD_WIN:    dout = {23'd0, win};
      SS_PD_CTRL:   dout = {24'd0, fifo_count, 2'b00, ovf, enable};
      default:      dout = 32'd0;
    endcase
  end

  ss_pd_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (last),
    .wdata   (rec),
    .pop     (pop),
    .rdata   (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_ss_peak_detect.sv
// Self-checking bench for ss_peak_detect: directed windows plus random windows against a reference model.
// Expected records are queued as stimulus is driven and popped as the DUT hands them out.
module tb_ss_peak_detect;

  logic        clk, reset_n;
  logic [31:0] din, dout, corr, out_data;
  logic [3:0]  addr;
  logic        strobe, sync, push_corr, out_valid, out_ready;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] s[$];

  ss_peak_detect #(.DEPTH(4), .WIN_RST(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .din       (din),
    .addr      (addr),
    .strobe    (strobe),
    .dout      (dout),
    .sync      (sync),
    .push_corr (push_corr),
    .corr      (corr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Independent reference: strict-greater peak search over a whole window.
  function automatic logic [31:0] model_rec(input logic [31:0] w[$], input logic [31:0] th);
    longint best = 0;
    longint v, m;
    int     sv;
    logic [7:0] bi = 8'd0;
    logic       bs = 1'b0;
    logic [21:0] m22;
    for (int i = 0; i < w.size(); i++) begin
      sv = int'(w[i]);
      v  = longint'(sv);
      m  = (v < 0) ? -v : v;
      if (m > 64'sd2147483647) m = 64'sd2147483647;
      if (m > best) begin
        best = m;
        bi   = 8'(i);
        bs   = (v < 0);
      end
    end
    m22 = (best > 64'sd4194303) ? 22'h3FFFFF : 22'(best);
    return {(best >= longint'(th)), bs, bi, m22};
  endfunction

  // Pops happen on the next rising edge, so sampling here sees exactly what leaves.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) checkOutput("sb_unexpected", 32'(exp_q.size()), 32'd1);
      else checkOutput("sb_record", out_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic regWrite(input logic [3:0] a, input logic [31:0] d);
    strobe = 1'b1;
    addr   = a;
    din    = d;
    tick();
    strobe = 1'b0;
  endtask

  task automatic checkReg(input string tag, input logic [3:0] a, input logic [31:0] expected);
    addr = a;
    #1;
    checkOutput(tag, dout, expected);
  endtask

  task automatic pushSample(input logic [31:0] v);
    push_corr = 1'b1;
    corr      = v;
    tick();
    push_corr = 1'b0;
  endtask

  // Drives a full window, queueing its expected record just before the closing sample.
  task automatic applyStimulus(input logic [31:0] w[$], input logic [31:0] expected);
    for (int i = 0; i < w.size(); i++) begin
      if (i == w.size() - 1) exp_q.push_back(expected);
      pushSample(w[i]);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    tick();
    checkOutput(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] th;
    reset_n = 1'b0; din = '0; addr = '0; strobe = 1'b0; sync = 1'b0;
    push_corr = 1'b0; corr = '0; out_ready = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkReg("rst_thresh", 4'd0, 32'd0);
    checkReg("rst_win", 4'd1, 32'd32);
    checkReg("rst_ctrl", 4'd2, 32'h1);
    checkReg("rst_other", 4'd7, 32'd0);

    // Peak at the first -200 wins over the later tie; valid appears right after the closing edge.
    regWrite(4'd0, 32'd100);
    regWrite(4'd1, 32'd4);
    checkReg("thresh_rb", 4'd0, 32'd100);
    checkReg("win_rb", 4'd1, 32'd4);
    s = '{32'd10, -32'd200, 32'd150};
    foreach (s[i]) pushSample(s[i]);
    checkOutput("pre_valid", {31'd0, out_valid}, 32'd0);
    exp_q.push_back(32'hC04000C8);
    pushSample(-32'd200);
    checkOutput("valid_latency", {31'd0, out_valid}, 32'd1);
    drain("drain_t2");

    regWrite(4'd1, 32'd2);
    s = '{32'd5, -32'd7};
    applyStimulus(s, 32'h40400007);
    drain("drain_t3");

    regWrite(4'd0, 32'd0);
    regWrite(4'd1, 32'd1);
    s = '{32'h80000000};
    applyStimulus(s, 32'hC03FFFFF);
    drain("drain_t4");

    regWrite(4'd1, 32'd2);
    s = '{32'd7, -32'd7};
    applyStimulus(s, 32'h80000007);
    drain("drain_tie");

    regWrite(4'd1, 32'd1);
    regWrite(4'd2, 32'd0);
    checkReg("ctrl_dis", 4'd2, 32'h0);
    for (int i = 0; i < 3; i++) pushSample(32'd50 + 32'(i));
    repeat (2) tick();
    checkOutput("disabled_valid", {31'd0, out_valid}, 32'd0);
    regWrite(4'd2, 32'd1);

    // Fill the FIFO with the consumer stalled, then overflow it once.
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(32'h80000000 | 32'(i));
      pushSample(32'(i));
    end
    checkReg("ovf_status", 4'd2, 32'h43);
    out_ready = 1'b1;
    drain("drain_t5");
    checkReg("ovf_sticky", 4'd2, 32'h3);
    regWrite(4'd2, 32'd3);
    checkReg("ovf_clear", 4'd2, 32'h1);

    // Sync restarts the window and swallows the push in its own cycle.
    regWrite(4'd1, 32'd4);
    pushSample(32'd500);
    pushSample(-32'd600);
    sync = 1'b1;
    pushSample(32'd1000);
    sync = 1'b0;
    s = '{32'd4, 32'd3, 32'd9, 32'd1};
    applyStimulus(s, 32'h80800009);
    drain("drain_t6");

    regWrite(4'd1, 32'd1);
    out_ready = 1'b0;
    for (int i = 10; i < 14; i++) begin
      exp_q.push_back(32'h80000000 | 32'(i));
      pushSample(32'(i));
    end
    out_ready = 1'b1;
    exp_q.push_back(32'h8000000E);
    pushSample(32'd14);
    checkReg("full_pushpop", 4'd2, 32'h41);
    drain("drain_t6b");
    checkReg("no_ovf", 4'd2, 32'h1);

    // Reset in the middle of a window; the partial window must not leak into the next one.
    regWrite(4'd0, 32'd77);
    regWrite(4'd1, 32'd4);
    pushSample(32'd900);
    pushSample(32'd800);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    checkReg("mid_rst_thresh", 4'd0, 32'd0);
    checkReg("mid_rst_win", 4'd1, 32'd32);
    checkReg("mid_rst_ctrl", 4'd2, 32'h1);
    tick();
    reset_n = 1'b1;
    tick();
    s = {};
    for (int i = 0; i < 32; i++) s.push_back(32'($urandom_range(0, 2000)) - 32'd1000);
    applyStimulus(s, model_rec(s, 32'd0));
    drain("drain_rst");

    // Random windows with magnitudes spanning small values through saturation.
    th = 32'($urandom_range(0, 32'h3FFFFF));
    regWrite(4'd0, th);
    regWrite(4'd1, 32'd8);
    for (int w = 0; w < 6; w++) begin
      s = {};
      for (int i = 0; i < 8; i++) begin
        logic [31:0] v;
        v = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) v = -v;
        s.push_back(v);
      end
      applyStimulus(s, model_rec(s, th));
    end
    drain("drain_rand");

    checkOutput("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
